// File: rtl/i2c_arb_pkg.sv
// Shared types and field widths for the i2c controller arbiter.
package i2c_arb_pkg;

    localparam int DEV_ADDR_W   = 7;
    localparam int INNER_ADDR_W = 8;
    localparam int DATA_W       = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/i2c_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_picker
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] win_o,
    output logic [IW-1:0]    idx_o,
    output logic             any_o
);

    always_comb begin
        int   j;
        logic found;
        win_o = '0;
        idx_o = '0;
        found = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr_i) + k) % N_REQ;
            if (!found && req_i[j]) begin
                found    = 1'b1;
                idx_o    = IW'(j);
                win_o[j] = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one i2c controller among N_REQ requesters;
// every output is a flop so nothing combinational reaches the requesters.
module i2c_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_REQ-1:0]               req,
    input  logic [N_REQ-1:0]               req_rw,
    input  logic [DEV_ADDR_W*N_REQ-1:0]    req_dev_addr,
    input  logic [INNER_ADDR_W*N_REQ-1:0]  req_inner_addr,
    input  logic [DATA_W*N_REQ-1:0]        req_wdata,
    output logic [N_REQ-1:0]               gnt,
    output logic [N_REQ-1:0]               ack,
    output logic                           err,
    output logic [DATA_W-1:0]              rdata,
    output logic                           busy,
    output logic                           i2c_send_en,
    output logic                           i2c_recv_en,
    output logic [DEV_ADDR_W-1:0]          i2c_dev_addr,
    output logic [INNER_ADDR_W-1:0]        i2c_inner_addr,
    output logic [DATA_W-1:0]              i2c_wdata,
    input  logic [DATA_W-1:0]              i2c_rdata,
    input  logic                           i2c_done
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    state_e                  state_q, state_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [N_REQ-1:0]        gnt_q, gnt_d, ack_q, ack_d;
    logic                    err_q, err_d, busy_q, busy_d;
    logic                    send_q, send_d, recv_q, recv_d, rw_q, rw_d;
    logic [DATA_W-1:0]       rdata_q, rdata_d, wdata_q, wdata_d;
    logic [DEV_ADDR_W-1:0]   dev_q, dev_d;
    logic [INNER_ADDR_W-1:0] inner_q, inner_d;

    logic [N_REQ-1:0]        pick_win;
    logic [IW-1:0]           pick_idx;
    logic                    pick_any;

    rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .win_o (pick_win),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        logic grant;
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        err_d   = 1'b0;
        rdata_d = rdata_q;
        send_d  = 1'b0;
        recv_d  = 1'b0;
        rw_d    = rw_q;
        dev_d   = dev_q;
        inner_d = inner_q;
        wdata_d = wdata_q;
        grant   = 1'b0;
        unique case (state_q)
            // Granting straight out of GAP keeps the idle-enable gap to one cycle.
            IDLE, GAP: begin
                gnt_d   = '0;
                state_d = IDLE;
                grant   = pick_any;
            end
            BUSY: begin
                send_d = !rw_q;
                recv_d = rw_q;
                if (i2c_done || cnt_q == CW'(TIMEOUT_CYC)) begin
                    // done wins over a coincident expiry
                    ack_d   = gnt_q;
                    err_d   = !i2c_done;
                    rdata_d = (i2c_done && rw_q) ? i2c_rdata : '0;
                    gnt_d   = '0;
                    send_d  = 1'b0;
                    recv_d  = 1'b0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant) begin
            state_d = BUSY;
            gnt_d   = pick_win;
            ptr_d   = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            cnt_d   = '0;
            rw_d    = req_rw[pick_idx];
            send_d  = !req_rw[pick_idx];
            recv_d  = req_rw[pick_idx];
            dev_d   = req_dev_addr[int'(pick_idx)*DEV_ADDR_W +: DEV_ADDR_W];
            inner_d = req_inner_addr[int'(pick_idx)*INNER_ADDR_W +: INNER_ADDR_W];
            wdata_d = req_wdata[int'(pick_idx)*DATA_W +: DATA_W];
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
            send_q  <= 1'b0;
            recv_q  <= 1'b0;
            rw_q    <= 1'b0;
            dev_q   <= '0;
            inner_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            send_q  <= send_d;
            recv_q  <= recv_d;
            rw_q    <= rw_d;
            dev_q   <= dev_d;
            inner_q <= inner_d;
            wdata_q <= wdata_d;
        end
    end

    assign gnt            = gnt_q;
    assign ack            = ack_q;
    assign err            = err_q;
    assign rdata          = rdata_q;
    assign busy           = busy_q;
    assign i2c_send_en    = send_q;
    assign i2c_recv_en    = recv_q;
    assign i2c_dev_addr   = dev_q;
    assign i2c_inner_addr = inner_q;
    assign i2c_wdata      = wdata_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter: completions checked against a scoreboard queue.
module tb_i2c_arbiter;

    localparam int N = 4;

    typedef struct {
        int         idx;
        logic [7:0] rd;
        logic       er;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req, req_rw, gnt, ack;
    logic [7*N-1:0] req_dev_addr;
    logic [8*N-1:0] req_inner_addr, req_wdata;
    logic           err, busy, send_en, recv_en, i2c_done;
    logic [7:0]     rdata, i2c_rdata, i2c_inner_addr, i2c_wdata;
    logic [6:0]     i2c_dev_addr;

    logic [N-1:0]   t_req, t_gnt, t_ack;
    logic           t_err, t_busy, t_send, t_recv, t_done;
    logic [7:0]     t_rdata, t_inner, t_wdata;
    logic [6:0]     t_dev;

    int   vectors = 0;
    int   errors  = 0;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    i2c_arbiter #(.N_REQ(N), .TIMEOUT_CYC(64)) dut (
        .clk(clk), .rst(rst), .req(req), .req_rw(req_rw),
        .req_dev_addr(req_dev_addr), .req_inner_addr(req_inner_addr), .req_wdata(req_wdata),
        .gnt(gnt), .ack(ack), .err(err), .rdata(rdata), .busy(busy),
        .i2c_send_en(send_en), .i2c_recv_en(recv_en), .i2c_dev_addr(i2c_dev_addr),
        .i2c_inner_addr(i2c_inner_addr), .i2c_wdata(i2c_wdata),
        .i2c_rdata(i2c_rdata), .i2c_done(i2c_done)
    );

    i2c_arbiter #(.N_REQ(N), .TIMEOUT_CYC(16)) dut_t (
        .clk(clk), .rst(rst), .req(t_req), .req_rw(req_rw),
        .req_dev_addr(req_dev_addr), .req_inner_addr(req_inner_addr), .req_wdata(req_wdata),
        .gnt(t_gnt), .ack(t_ack), .err(t_err), .rdata(t_rdata), .busy(t_busy),
        .i2c_send_en(t_send), .i2c_recv_en(t_recv), .i2c_dev_addr(t_dev),
        .i2c_inner_addr(t_inner), .i2c_wdata(t_wdata),
        .i2c_rdata(i2c_rdata), .i2c_done(t_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_fields(input int idx, input logic rw, input logic [6:0] dev,
                              input logic [7:0] inner, input logic [7:0] wd);
        req_rw[idx]              = rw;
        req_dev_addr[idx*7 +: 7] = dev;
        req_inner_addr[idx*8 +: 8] = inner;
        req_wdata[idx*8 +: 8]    = wd;
    endtask

    // Full transaction on the main instance; done is sampled at the edge ending BUSY cycle done_c.
    task automatic do_txn(input int idx, input logic rw, input logic [6:0] dev,
                          input logic [7:0] inner, input logic [7:0] wd,
                          input logic [7:0] rd, input int done_c);
        int en_n, bad_n;
        set_fields(idx, rw, dev, inner, wd);
        sb.push_back('{idx, rw ? rd : 8'h00, 1'b0});
        i2c_rdata = rd;
        req[idx]  = 1'b1;
        en_n = 0;
        bad_n = 0;
        for (int c = 1; c <= done_c + 4; c++) begin
            @(negedge clk);
            if (c == 1) begin
                check("gnt", gnt, 32'd1 << idx);
                check("busy", busy, 1);
                check("dev_addr", i2c_dev_addr, dev);
                check("inner_addr", i2c_inner_addr, inner);
                check("wdata", i2c_wdata, wd);
            end
            if (rw ? recv_en : send_en) en_n++;
            if (rw ? send_en : recv_en) bad_n++;
            if (ack[idx]) req[idx] = 1'b0;
            i2c_done = (c == done_c);
        end
        check("en_cycles", en_n, done_c);
        check("wrong_en", bad_n, 0);
    endtask

    // Scoreboard side: every ack/err on the main instance must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            check("en_excl", {31'd0, send_en & recv_en}, 0);
            if (ack != '0 || err) begin
                if (sb.size() == 0) begin
                    check("ack_unexpected", {28'd0, ack}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack_idx", ack, 32'd1 << mon_e.idx);
                    check("ack_rdata", rdata, mon_e.rd);
                    check("ack_err", err, mon_e.er);
                end
            end
        end
    end

    initial begin
        int ng, hi, lo, g, a;
        logic [3:0] order [4];
        order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b1000; order[3] = 4'b0001;

        rst = 1'b1; req = '0; req_rw = '0; t_req = '0; t_done = 1'b0; i2c_done = 1'b0;
        req_dev_addr = '0; req_inner_addr = '0; req_wdata = '0; i2c_rdata = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt", gnt, 0);
        check("rst_ack", ack, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        check("rst_busy", busy, 0);
        check("rst_send", send_en, 0);
        check("rst_recv", recv_en, 0);
        check("rst_dev", i2c_dev_addr, 0);
        check("rst_inner", i2c_inner_addr, 0);
        check("rst_wdata", i2c_wdata, 0);
        rst = 1'b0;
        @(negedge clk);

        // single write, single read
        do_txn(1, 1'b0, 7'h50, 8'h10, 8'hA5, 8'hFF, 21);
        do_txn(2, 1'b1, 7'h21, 8'h05, 8'h00, 8'h3C, 5);

        // fields changed and req dropped mid-BUSY
        set_fields(0, 1'b0, 7'h33, 8'h44, 8'h11);
        sb.push_back('{0, 8'h00, 1'b0});
        req[0] = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 3) begin
                req_wdata[7:0] = 8'hEE;
                req[0] = 1'b0;
            end
            if (c == 5) begin
                check("wdata_frozen", i2c_wdata, 8'h11);
                check("send_after_drop", send_en, 1);
            end
            i2c_done = (c == 8);
        end

        // reset mid-BUSY: no ack, pointer back to 0
        set_fields(2, 1'b0, 7'h12, 8'h34, 8'h56);
        req[2] = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_send", send_en, 1);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_send", send_en, 0);
        check("midrst_recv", recv_en, 0);
        check("midrst_gnt", gnt, 0);
        check("midrst_busy", busy, 0);
        req = '0;
        @(negedge clk);
        rst = 1'b0;
        set_fields(3, 1'b0, 7'h7F, 8'h01, 8'h02);
        req = 4'b1100;
        sb.push_back('{2, 8'h00, 1'b0});
        @(negedge clk);
        check("post_rst_gnt", gnt, 4'b0100);
        i2c_done = 1'b1;
        req = '0;
        @(negedge clk);
        i2c_done = 1'b0;
        repeat (3) @(negedge clk);

        // contention from ptr = 0
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        set_fields(0, 1'b0, 7'h01, 8'h00, 8'h00);
        set_fields(1, 1'b0, 7'h02, 8'h00, 8'h00);
        set_fields(3, 1'b1, 7'h03, 8'h00, 8'h00);
        i2c_rdata = 8'h77;
        req = 4'b1011;
        ng = 0; hi = 0; lo = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (send_en || recv_en) begin
                if (hi == 0 && ng < 4) begin
                    if (ng > 0) check("rr_gap", lo, 1);
                    check("rr_order", gnt, order[ng]);
                    sb.push_back('{(ng == 2) ? 3 : (ng == 1 ? 1 : 0), (ng == 2) ? 8'h77 : 8'h00, 1'b0});
                    ng++;
                    if (ng == 4) req = '0;
                end
                hi++;
                lo = 0;
            end else begin
                hi = 0;
                lo++;
            end
            i2c_done = (hi == 3);
        end
        i2c_done = 1'b0;
        check("rr_grants", ng, 4);

        // timeout on the TIMEOUT_CYC = 16 instance, then done coincident with expiry
        set_fields(0, 1'b0, 7'h44, 8'h55, 8'h66);
        t_req[0] = 1'b1;
        g = 0; a = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (g == 0 && t_gnt != '0) begin
                g = c;
                check("to_gnt", t_gnt, 4'b0001);
                check("to_send", {t_send, t_recv}, 2'b10);
                check("to_fields", {t_dev, t_inner, t_wdata}, {7'h44, 8'h55, 8'h66});
            end
            if (a == 0 && t_ack != '0) begin
                a = c;
                check("to_ack", t_ack, 4'b0001);
                check("to_err", t_err, 1);
                check("to_rdata", t_rdata, 0);
                t_req = '0;
            end
        end
        check("to_latency", a - g, 17);
        check("to_idle", t_busy, 0);

        req_rw[1] = 1'b1;
        i2c_rdata = 8'h5A;
        t_req[1] = 1'b1;
        a = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c == 1) check("co_gnt", t_gnt, 4'b0010);
            if (a == 0 && t_ack != '0) begin
                a = c;
                check("co_err", t_err, 0);
                check("co_rdata", t_rdata, 8'h5A);
                t_req = '0;
            end
            t_done = (c == 17);
        end
        check("co_latency", a, 18);

        check("sb_drain", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
